// File: rtl/proc_pkg.sv
// Shared processor definitions: opcodes, instruction field positions, the NOP word
// and helpers that report which registers an instruction reads.
package proc_pkg;

    localparam logic [4:0] OP_ALU  = 5'd0;
    localparam logic [4:0] OP_BNE  = 5'd2;
    localparam logic [4:0] OP_ADDI = 5'd5;
    localparam logic [4:0] OP_BLT  = 5'd6;
    localparam logic [4:0] OP_SW   = 5'd7;
    localparam logic [4:0] OP_LW   = 5'd8;

    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RD_HI = 26;
    localparam int RD_LO = 22;
    localparam int RS_HI = 21;
    localparam int RS_LO = 17;
    localparam int RT_HI = 16;
    localparam int RT_LO = 12;

    // add $0,$0,$0
    localparam logic [31:0] NOP = 32'd0;

    // Source registers of one instruction. bIsStoreData marks the sw store-data
    // read, which the memory-stage bypass covers without a stall.
    typedef struct packed {
        logic       aUsed;
        logic [4:0] aReg;
        logic       bUsed;
        logic [4:0] bReg;
        logic       bIsStoreData;
    } srcRegsT;

    function automatic logic [4:0] fieldOp(input logic [31:0] ir);
        return ir[OP_HI:OP_LO];
    endfunction

    function automatic logic [4:0] fieldRd(input logic [31:0] ir);
        return ir[RD_HI:RD_LO];
    endfunction

    function automatic logic [4:0] fieldRs(input logic [31:0] ir);
        return ir[RS_HI:RS_LO];
    endfunction

    function automatic logic [4:0] fieldRt(input logic [31:0] ir);
        return ir[RT_HI:RT_LO];
    endfunction

    function automatic srcRegsT srcRegs(input logic [31:0] ir);
        srcRegsT s;
        s = '0;
        case (fieldOp(ir))
            OP_ALU: begin
                s.aUsed = 1'b1; s.aReg = fieldRs(ir);
                s.bUsed = 1'b1; s.bReg = fieldRt(ir);
            end
            OP_ADDI, OP_LW: begin
                s.aUsed = 1'b1; s.aReg = fieldRs(ir);
            end
            OP_SW: begin
                s.aUsed = 1'b1; s.aReg = fieldRs(ir);
                s.bUsed = 1'b1; s.bReg = fieldRd(ir);
                s.bIsStoreData = 1'b1;
            end
            OP_BNE, OP_BLT: begin
                s.aUsed = 1'b1; s.aReg = fieldRd(ir);
                s.bUsed = 1'b1; s.bReg = fieldRs(ir);
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a valid lw in D/X whose destination
// is read by the F/D instruction (store data of sw excepted).
module load_use_detect
    import proc_pkg::*;
(
    input  logic [31:0] dxIR,
    input  logic        dxValid,
    input  logic [31:0] fdIR,
    output logic        luh
);

    srcRegsT    src;
    logic [4:0] dxRd;
    logic       dxIsLoad;
    logic       matchA;
    logic       matchB;

    always_comb begin
        src      = srcRegs(fdIR);
        dxRd     = fieldRd(dxIR);
        dxIsLoad = dxValid && (fieldOp(dxIR) == OP_LW) && (dxRd != 5'd0);
        matchA   = src.aUsed && (src.aReg == dxRd);
        matchB   = src.bUsed && (src.bReg == dxRd) && !src.bIsStoreData;
        luh      = dxIsLoad && (matchA || matchB);
    end

endmodule

// File: rtl/dx_stage.sv
// Decode/execute pipeline register: captures the decoded instruction and operands,
// inserts load-use bubbles, and applies flush and hold with fixed priority.
module dx_stage #(
    parameter int          CNT_W = 16,
    parameter logic [31:0] NOP   = proc_pkg::NOP
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      fdIR,
    input  logic [31:0]      fdPC,
    input  logic [31:0]      regA,
    input  logic [31:0]      regB,
    input  logic             flush,
    input  logic             hold,
    output logic [31:0]      dxIR,
    output logic [31:0]      dxPC,
    output logic [31:0]      dxA,
    output logic [31:0]      dxB,
    output logic             dxValid,
    output logic             stallFD,
    output logic [CNT_W-1:0] bubbleCount
);

    logic             luh;
    logic [31:0]      nextIR;
    logic [31:0]      nextPC;
    logic [31:0]      nextA;
    logic [31:0]      nextB;
    logic             nextValid;
    logic [CNT_W-1:0] nextCount;

    load_use_detect uDetect (
        .dxIR    (dxIR),
        .dxValid (dxValid),
        .fdIR    (fdIR),
        .luh     (luh)
    );

    // Priority: flush, then hold, then load-use bubble, then normal advance.
    always_comb begin
        nextIR    = dxIR;
        nextPC    = dxPC;
        nextA     = dxA;
        nextB     = dxB;
        nextValid = dxValid;
        nextCount = bubbleCount;
        stallFD   = 1'b0;
        if (flush) begin
            nextIR    = NOP;
            nextPC    = 32'd0;
            nextA     = 32'd0;
            nextB     = 32'd0;
            nextValid = 1'b0;
        end else if (hold) begin
            stallFD = 1'b1;
        end else if (luh) begin
            nextIR    = NOP;
            nextPC    = 32'd0;
            nextA     = 32'd0;
            nextB     = 32'd0;
            nextValid = 1'b0;
            stallFD   = 1'b1;
            if (bubbleCount != {CNT_W{1'b1}}) begin
                nextCount = bubbleCount + 1'b1;
            end
        end else begin
            nextIR    = fdIR;
            nextPC    = fdPC;
            nextA     = regA;
            nextB     = regB;
            nextValid = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dxIR        <= NOP;
            dxPC        <= 32'd0;
            dxA         <= 32'd0;
            dxB         <= 32'd0;
            dxValid     <= 1'b0;
            bubbleCount <= '0;
        end else begin
            dxIR        <= nextIR;
            dxPC        <= nextPC;
            dxA         <= nextA;
            dxB         <= nextB;
            dxValid     <= nextValid;
            bubbleCount <= nextCount;
        end
    end

endmodule

// File: tb/tb_dx_stage.sv
// Directed bench for dx_stage: load-use bubbles, sw store-data exception, flush,
// hold, asynchronous reset and counter saturation (second instance with CNT_W = 2).
module tb_dx_stage;

    logic        clock;
    logic        reset;
    logic [31:0] fdIR;
    logic [31:0] fdPC;
    logic [31:0] regA;
    logic [31:0] regB;
    logic        flush;
    logic        hold;
    logic [31:0] dxIR, dxPC, dxA, dxB;
    logic        dxValid, stallFD;
    logic [15:0] bubbleCount;
    logic [31:0] dxIR2, dxPC2, dxA2, dxB2;
    logic        dxValid2, stallFD2;
    logic [1:0]  bubbleCount2;

    int total = 0;
    int bad   = 0;

    dx_stage dut (
        .clock(clock), .reset(reset), .fdIR(fdIR), .fdPC(fdPC), .regA(regA), .regB(regB),
        .flush(flush), .hold(hold), .dxIR(dxIR), .dxPC(dxPC), .dxA(dxA), .dxB(dxB),
        .dxValid(dxValid), .stallFD(stallFD), .bubbleCount(bubbleCount)
    );

    dx_stage #(.CNT_W(2)) dutSmall (
        .clock(clock), .reset(reset), .fdIR(fdIR), .fdPC(fdPC), .regA(regA), .regB(regB),
        .flush(flush), .hold(hold), .dxIR(dxIR2), .dxPC(dxPC2), .dxA(dxA2), .dxB(dxB2),
        .dxValid(dxValid2), .stallFD(stallFD2), .bubbleCount(bubbleCount2)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] enc(input int op, input int rd, input int rs, input int rt, input int imm);
        logic [31:0] w;
        w = (32'(op) << 27) | (32'(rd) << 22) | (32'(rs) << 17) | (32'(rt) << 12) | (32'(imm) & 32'h1ffff);
        return w;
    endfunction

    logic [31:0] LW3, ADD4, SW_DATA, SW_BASE, LW0, ADD0, BNE3;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; fdIR = 32'd0; fdPC = 32'd0; regA = 32'd0; regB = 32'd0;
        flush = 1'b0; hold = 1'b0;
        #2;
        total++; if (dxIR !== 32'd0) begin bad++; $display("FAIL reset_ir got=%h exp=%h", dxIR, 32'd0); end
        total++; if (dxValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", dxValid); end
        total++; if (bubbleCount !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bubbleCount); end
        total++; if (stallFD !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stallFD); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_load_use();
        fdIR = LW3; fdPC = 32'd10; regA = 32'd100; regB = 32'd200;
        tick();
        total++; if (dxIR !== LW3 || dxPC !== 32'd10 || dxA !== 32'd100 || dxB !== 32'd200 || dxValid !== 1'b1) begin
            bad++; $display("FAIL lu_load got=%h/%h/%h/%h/%b exp=%h/a/64/c8/1", dxIR, dxPC, dxA, dxB, dxValid, LW3);
        end
        fdIR = ADD4; fdPC = 32'd11; regA = 32'd7; regB = 32'd8;
        #1;
        total++; if (stallFD !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", stallFD); end
        tick();
        total++; if (dxIR !== 32'd0 || dxPC !== 32'd0 || dxA !== 32'd0 || dxB !== 32'd0 || dxValid !== 1'b0) begin
            bad++; $display("FAIL lu_bubble got=%h/%h/%h/%h/%b exp=0/0/0/0/0", dxIR, dxPC, dxA, dxB, dxValid);
        end
        total++; if (stallFD !== 1'b0) begin bad++; $display("FAIL lu_stall_drop got=%b exp=0", stallFD); end
        total++; if (bubbleCount !== 16'd1) begin bad++; $display("FAIL lu_count got=%0d exp=1", bubbleCount); end
        tick();
        total++; if (dxIR !== ADD4 || dxPC !== 32'd11 || dxA !== 32'd7 || dxValid !== 1'b1) begin
            bad++; $display("FAIL lu_consumer got=%h/%h/%h/%b exp=%h/b/7/1", dxIR, dxPC, dxA, dxValid, ADD4);
        end
    endtask

    task automatic test_sw_store_data();
        fdIR = LW3;
        tick();
        fdIR = SW_DATA;
        #1;
        total++; if (stallFD !== 1'b0) begin bad++; $display("FAIL swdata_stall got=%b exp=0", stallFD); end
        tick();
        total++; if (dxIR !== SW_DATA || dxValid !== 1'b1 || bubbleCount !== 16'd1) begin
            bad++; $display("FAIL swdata_pass got=%h/%b/%0d exp=%h/1/1", dxIR, dxValid, bubbleCount, SW_DATA);
        end
    endtask

    task automatic test_sw_base();
        fdIR = LW3;
        tick();
        fdIR = SW_BASE;
        #1;
        total++; if (stallFD !== 1'b1) begin bad++; $display("FAIL swbase_stall got=%b exp=1", stallFD); end
        tick();
        total++; if (dxIR !== 32'd0 || dxValid !== 1'b0 || bubbleCount !== 16'd2) begin
            bad++; $display("FAIL swbase_bubble got=%h/%b/%0d exp=0/0/2", dxIR, dxValid, bubbleCount);
        end
        tick();
        total++; if (dxIR !== SW_BASE || dxValid !== 1'b1) begin
            bad++; $display("FAIL swbase_enter got=%h/%b exp=%h/1", dxIR, dxValid, SW_BASE);
        end
    endtask

    task automatic test_zero_reg();
        fdIR = LW0;
        tick();
        fdIR = ADD0;
        #1;
        total++; if (stallFD !== 1'b0) begin bad++; $display("FAIL zero_stall got=%b exp=0", stallFD); end
        tick();
        total++; if (dxIR !== ADD0 || bubbleCount !== 16'd2) begin
            bad++; $display("FAIL zero_pass got=%h/%0d exp=%h/2", dxIR, bubbleCount, ADD0);
        end
    endtask

    task automatic test_branch();
        fdIR = LW3;
        tick();
        fdIR = BNE3;
        #1;
        total++; if (stallFD !== 1'b1) begin bad++; $display("FAIL bne_stall got=%b exp=1", stallFD); end
        tick();
        total++; if (dxIR !== 32'd0 || dxValid !== 1'b0 || bubbleCount !== 16'd3) begin
            bad++; $display("FAIL bne_bubble got=%h/%b/%0d exp=0/0/3", dxIR, dxValid, bubbleCount);
        end
        tick();
        total++; if (dxIR !== BNE3) begin bad++; $display("FAIL bne_enter got=%h exp=%h", dxIR, BNE3); end
    endtask

    task automatic test_flush();
        fdIR = LW3;
        tick();
        fdIR = ADD4; flush = 1'b1;
        #1;
        total++; if (stallFD !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", stallFD); end
        tick();
        flush = 1'b0;
        total++; if (dxIR !== 32'd0 || dxValid !== 1'b0 || bubbleCount !== 16'd3) begin
            bad++; $display("FAIL flush_state got=%h/%b/%0d exp=0/0/3", dxIR, dxValid, bubbleCount);
        end
    endtask

    task automatic test_hold();
        fdIR = ADD4; fdPC = 32'd20; regA = 32'd5; regB = 32'd6;
        tick();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            regA = 32'h1000 + 32'(i); fdIR = enc(5, i + 1, 2, 0, i); fdPC = 32'd30 + 32'(i);
            #1;
            total++; if (stallFD !== 1'b1) begin bad++; $display("FAIL hold_stall%0d got=%b exp=1", i, stallFD); end
            tick();
            total++; if (dxIR !== ADD4 || dxA !== 32'd5 || dxB !== 32'd6 || dxPC !== 32'd20) begin
                bad++; $display("FAIL hold_keep%0d got=%h/%h/%h/%h exp=%h/5/6/14", i, dxIR, dxA, dxB, dxPC, ADD4);
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_hold_luh();
        fdIR = LW3;
        tick();
        fdIR = ADD4; hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (stallFD !== 1'b1) begin bad++; $display("FAIL holdluh_stall%0d got=%b exp=1", i, stallFD); end
            tick();
            total++; if (dxIR !== LW3 || bubbleCount !== 16'd3) begin
                bad++; $display("FAIL holdluh_keep%0d got=%h/%0d exp=%h/3", i, dxIR, bubbleCount, LW3);
            end
        end
        hold = 1'b0;
        #1;
        total++; if (stallFD !== 1'b1) begin bad++; $display("FAIL holdluh_pending got=%b exp=1", stallFD); end
        tick();
        total++; if (dxIR !== 32'd0 || dxValid !== 1'b0 || bubbleCount !== 16'd4 || stallFD !== 1'b0) begin
            bad++; $display("FAIL holdluh_bubble got=%h/%b/%0d/%b exp=0/0/4/0", dxIR, dxValid, bubbleCount, stallFD);
        end
        tick();
        total++; if (dxIR !== ADD4) begin bad++; $display("FAIL holdluh_enter got=%h exp=%h", dxIR, ADD4); end
    endtask

    task automatic test_reset_mid();
        fdIR = LW3;
        tick();
        fdIR = ADD4;
        #1;
        total++; if (stallFD !== 1'b1 || dxValid !== 1'b1) begin
            bad++; $display("FAIL rstmid_pre got=%b/%b exp=1/1", stallFD, dxValid);
        end
        #1;
        reset = 1'b1;
        #1;
        total++; if (dxIR !== 32'd0 || dxValid !== 1'b0 || bubbleCount !== 16'd0 || stallFD !== 1'b0) begin
            bad++; $display("FAIL rstmid_clear got=%h/%b/%0d/%b exp=0/0/0/0", dxIR, dxValid, bubbleCount, stallFD);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            fdIR = LW3;
            tick();
            fdIR = ADD4;
            tick();
            tick();
        end
        total++; if (bubbleCount2 !== 2'd3) begin bad++; $display("FAIL sat_small got=%0d exp=3", bubbleCount2); end
        total++; if (bubbleCount !== 16'd5) begin bad++; $display("FAIL sat_wide got=%0d exp=5", bubbleCount); end
    endtask

    initial begin
        LW3     = enc(8, 3, 1, 0, 0);
        ADD4    = enc(0, 4, 3, 2, 0);
        SW_DATA = enc(7, 3, 5, 0, 4);
        SW_BASE = enc(7, 5, 3, 0, 0);
        LW0     = enc(8, 0, 1, 0, 0);
        ADD0    = enc(0, 4, 0, 0, 0);
        BNE3    = enc(2, 3, 6, 0, 0);
        test_reset();
        test_load_use();
        test_sw_store_data();
        test_sw_base();
        test_zero_reg();
        test_branch();
        test_flush();
        test_hold();
        test_hold_luh();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
